// File: rtl/memctrl_pkg.sv
// Shared definitions for the data-cache line memory controller.
// Contents: FSM state encoding, default bus widths, line-offset constant.
// Imported by dcache_mem_ctrl and mem_latency_timer.
package memctrl_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int LINE_W_DEF = 64;

  // Word offset inside a 4-word line. The memory side always sees it as zero.
  localparam logic [1:0] LINE_OFS = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WB   = 3'd1,
    ST_FILL = 3'd2,
    ST_DONE = 3'd3,
    ST_DMA  = 3'd4
  } state_t;

endpackage

// File: rtl/dcache_mem_ctrl_timer.sv
// Purpose: counts the cycles of one memory line access (0..MEM_LATENCY-1).
// Latency: done is asserted combinationally in the final access cycle.
// Backpressure: none. load clears the count; en advances it while a WB/FILL runs.
// Ports: clk, reset_n, load (state entry), en (access in progress), done (last cycle).
module mem_latency_timer
  import memctrl_pkg::*;
#(
  parameter int MEM_LATENCY = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam logic [3:0] LAST = 4'(MEM_LATENCY - 1);

  logic [3:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= 4'd0;
    end else if (en && !done) begin
      count <= count + 4'd1;
    end
  end

  assign done = en && (count == LAST);

endmodule

// File: rtl/dcache_mem_ctrl.sv
// Purpose: serialises data-cache write-back/fill onto the line memory and shares the bus with DMA.
// Latency: fill or write-back MEM_LATENCY+1 cycles, write-back+fill 2*MEM_LATENCY+1, from acceptance to c_ready.
// Backpressure: the cache is stalled while dma_bg is high; DMA waits for IDLE when a cache request is running.
// Ports: cache side c_*, DMA side dma_br/dma_bg, memory side mem_*.
// Optional: define DCACHE_MEM_STATS_EN to add saturating stat_fills/stat_wbs/stat_dma_grants outputs.
module dcache_mem_ctrl
  import memctrl_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int LINE_W      = LINE_W_DEF,
  parameter int MEM_LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              c_read_m,
  input  logic              c_write_m,
  input  logic [ADDR_W-1:0] c_address,
  input  logic [ADDR_W-1:0] c_wb_address,
  input  logic [LINE_W-1:0] c_wdata,
  output logic [LINE_W-1:0] c_rdata,
  output logic              c_ready,
  input  logic              dma_br,
  output logic              dma_bg,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata
`ifdef DCACHE_MEM_STATS_EN
  ,
  output logic [15:0]       stat_fills,
  output logic [15:0]       stat_wbs,
  output logic [15:0]       stat_dma_grants
`endif
);

  state_t state, state_next;
  logic   accept;
  logic   t_done;
  logic   cache_pri;
  logic   rd_q;
  logic [ADDR_W-1:2] fill_addr_q;
  logic [ADDR_W-1:2] wb_addr_q;
  logic [LINE_W-1:0] wdata_q;

  // Word-offset bits are discarded on purpose: memory is always addressed per line.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^{c_address[1:0], c_wb_address[1:0]};

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dma_br && !cache_pri) begin
          state_next = ST_DMA;
        end else if (c_write_m) begin
          state_next = ST_WB;
          accept     = 1'b1;
        end else if (c_read_m) begin
          state_next = ST_FILL;
          accept     = 1'b1;
        end
      end
      ST_WB:   if (t_done) state_next = rd_q ? ST_FILL : ST_DONE;
      ST_FILL: if (t_done) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      ST_DMA:  if (!dma_br) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // The counter restarts on every state change, so WB->FILL gets a full latency window.
  mem_latency_timer #(.MEM_LATENCY(MEM_LATENCY)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (state_next != state),
    .en      ((state == ST_WB) || (state == ST_FILL)),
    .done    (t_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cache_pri   <= 1'b0;
      rd_q        <= 1'b0;
      fill_addr_q <= '0;
      wb_addr_q   <= '0;
      wdata_q     <= '0;
      c_rdata     <= '0;
    end else begin
      state <= state_next;
      // The whole request is frozen at acceptance; later input changes are ignored.
      if (accept) begin
        rd_q        <= c_read_m;
        fill_addr_q <= c_address[ADDR_W-1:2];
        wb_addr_q   <= c_wb_address[ADDR_W-1:2];
        wdata_q     <= c_wdata;
      end
      // Fairness: after a DMA tenure the cache gets the next slot, unless it has nothing to do.
      if (state == ST_IDLE && (accept || !(c_read_m || c_write_m))) begin
        cache_pri <= 1'b0;
      end else if (state == ST_DMA && !dma_br) begin
        cache_pri <= 1'b1;
      end
      if (state == ST_FILL && t_done) begin
        c_rdata <= mem_rdata;
      end
    end
  end

  // Moore outputs decoded from the state register: an async reset drops them at once.
  assign mem_write   = (state == ST_WB);
  assign mem_read    = (state == ST_FILL);
  assign c_ready     = (state == ST_DONE);
  assign dma_bg      = (state == ST_DMA);
  assign mem_address = (state == ST_WB)   ? {wb_addr_q, LINE_OFS}   :
                       (state == ST_FILL) ? {fill_addr_q, LINE_OFS} : '0;
  assign mem_wdata   = (state == ST_WB) ? wdata_q : '0;

`ifdef DCACHE_MEM_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_fills      <= 16'd0;
      stat_wbs        <= 16'd0;
      stat_dma_grants <= 16'd0;
    end else begin
      if (state == ST_FILL && t_done && stat_fills != 16'hFFFF)
        stat_fills <= stat_fills + 16'd1;
      if (state == ST_WB && t_done && stat_wbs != 16'hFFFF)
        stat_wbs <= stat_wbs + 16'd1;
      if (state != ST_DMA && state_next == ST_DMA && stat_dma_grants != 16'hFFFF)
        stat_dma_grants <= stat_dma_grants + 16'd1;
    end
  end
`endif

endmodule
